dmem_responder: RTL and testbench

- Responder end of the core data port: accepts single-word load/store requests issued by the load/store unit and answers with a one-cycle `data_ready` pulse.
- Backed by an internal word-addressed RAM with a configurable number of wait states.
- Sits between the core data port and the top-level memory map, in place of an external bus slave, for simulation and FPGA builds.

---
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 tb/tb_dmem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-addressed RAM responder for the core data port, with a fixed number of wait states per request.
// Optional protocol checker (sticky proto_err) is built only when DMEM_PROTO_CHECK_EN is defined.
module dmem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_start,
  input  logic        data_write,
  input  logic [29:0] data_addr,
  input  logic [31:0] data_data_wr,
  input  logic [3:0]  data_data_be,
  output logic        data_ready,
  output logic [31:0] data_data_rd,
  output logic        proto_err
);

  // state  | meaning
  // S_IDLE | no request outstanding
  // S_WAIT | request latched, counting down wait states
  // S_RESP | data_ready cycle; a pending store commits at its closing edge
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept;
  logic            in_oob;

  logic            wr_q;
  logic            oob_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;

  logic            commit;
  logic [AW-1:0]   rd_idx;
  logic            rd_is_wr;
  logic            rd_oob;
  logic [31:0]     fwd_word;
  logic            ready_nxt;
  logic [31:0]     rd_nxt;

  logic [31:0]     mem [DEPTH];

  generate
    if (AW < 30) begin : g_oob
      assign in_oob = |data_addr[29:AW];
    end else begin : g_no_oob
      assign in_oob = 1'b0;
    end
  endgenerate

  assign accept = data_start && ((state == S_IDLE) || (state == S_RESP));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_RESP: begin
        if (data_start) begin
          cnt_nxt   = WS4;
          state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read data is captured on the edge entering RESP. With zero wait states that edge can
  // coincide with the previous store's commit, so the committing bytes are forwarded.
  always_comb begin
    commit    = (state == S_RESP) && wr_q && !oob_q;
    rd_idx    = accept ? data_addr[AW-1:0] : idx_q;
    rd_is_wr  = accept ? data_write : wr_q;
    rd_oob    = accept ? in_oob : oob_q;
    fwd_word  = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) fwd_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
    ready_nxt = (state_nxt == S_RESP);
    rd_nxt    = (ready_nxt && !rd_is_wr && !rd_oob) ? fwd_word : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_ready   <= 1'b0;
      data_data_rd <= 32'h0;
    end else begin
      data_ready   <= ready_nxt;
      data_data_rd <= rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= data_write;
      oob_q   <= in_oob;
      idx_q   <= data_addr[AW-1:0];
      wdata_q <= data_data_wr;
      be_q    <= data_data_be;
    end
  end

  // Reset during RESP abandons the store as well.
  always_ff @(posedge clk) begin
    if (commit && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

`ifdef DMEM_PROTO_CHECK_EN
  logic start_in_wait;
  logic oob_accept;

  assign start_in_wait = data_start && (state == S_WAIT);
  assign oob_accept    = accept && in_oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (start_in_wait || oob_accept) begin
      proto_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      if (start_in_wait) $error("dmem_responder: data_start while a request is outstanding");
      if (oob_accept)    $error("dmem_responder: out-of-range address %h", data_addr);
    end
  end
`endif
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 3 wait states.
module tb_dmem_responder;

`ifdef DMEM_PROTO_CHECK_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start = '0;
  logic [2:0]  write = '0;
  logic [29:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic [2:0]  ready;
  logic [31:0] rd    [3];
  logic [2:0]  perr;

  int tests = 0;
  int fails = 0;
  vec_t vecs [20];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(4096), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .data_start(start[0]), .data_write(write[0]),
    .data_addr(addr[0]), .data_data_wr(wdata[0]), .data_data_be(be[0]),
    .data_ready(ready[0]), .data_data_rd(rd[0]), .proto_err(perr[0]));

  dmem_responder #(.DEPTH(4096), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .data_start(start[1]), .data_write(write[1]),
    .data_addr(addr[1]), .data_data_wr(wdata[1]), .data_data_be(be[1]),
    .data_ready(ready[1]), .data_data_rd(rd[1]), .proto_err(perr[1]));

  dmem_responder #(.DEPTH(4096), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .data_start(start[2]), .data_write(write[2]),
    .data_addr(addr[2]), .data_data_wr(wdata[2]), .data_data_be(be[2]),
    .data_ready(ready[2]), .data_data_rd(rd[2]), .proto_err(perr[2]));

  function automatic int wsv(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge and follow it to the end of its response.
  task automatic txn(input int k, input logic w, input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rd, input string name);
    int lat;
    start[k] = 1'b1; write[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    @(negedge clk);
    start[k] = 1'b0;
    lat = 1;
    while (!ready[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(wsv(k) + 1));
    if (ready[k]) check({name, " data"}, rd[k], exp_rd);
    @(negedge clk);
    check({name, " ready low after"}, {31'b0, ready[k]}, 32'h0);
    check({name, " rd zero after"}, rd[k], 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nready;
    int first;
    logic [31:0] first_rd;

    for (int k = 0; k < 3; k++) begin
      addr[k] = '0; wdata[k] = '0; be[k] = '0;
    end

    vecs[0]  = '{1'b1, 30'h10,       32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 30'h10,       32'h0,        4'hF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 30'h20,       32'h11223344, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 30'h20,       32'hAABBCCDD, 4'h5, 32'h0};
    vecs[4]  = '{1'b0, 30'h20,       32'h0,        4'hF, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 30'h21,       32'h01020304, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 30'h21,       32'hCAFEF00D, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 30'h21,       32'h0,        4'hF, 32'h01020304};
    vecs[8]  = '{1'b1, 30'h22,       32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 30'h22,       32'h00000000, 4'h8, 32'h0};
    vecs[10] = '{1'b0, 30'h22,       32'h0,        4'hF, 32'h00FFFFFF};
    vecs[11] = '{1'b0, 30'h10,       32'h0,        4'h0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 30'h0,        32'h00000BAD, 4'hF, 32'h0};
    vecs[13] = '{1'b1, 30'h1000,     32'hFFFFFFFF, 4'hF, 32'h0};
    vecs[14] = '{1'b0, 30'h0,        32'h0,        4'hF, 32'h00000BAD};
    vecs[15] = '{1'b0, 30'h1000,     32'h0,        4'hF, 32'h0};
    vecs[16] = '{1'b1, 30'hFFF,      32'h12345678, 4'hF, 32'h0};
    vecs[17] = '{1'b0, 30'hFFF,      32'h0,        4'hF, 32'h12345678};
    vecs[18] = '{1'b0, 30'h3FFFFFFF, 32'h0,        4'hF, 32'h0};
    vecs[19] = '{1'b0, 30'h1FFF,     32'h0,        4'hF, 32'h0};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset ready[%0d]", k), {31'b0, ready[k]}, 32'h0);
      check($sformatf("reset rd[%0d]", k), rd[k], 32'h0);
      check($sformatf("reset proto_err[%0d]", k), {31'b0, perr[k]}, 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table of single transactions on the one-wait-state instance.
    for (int i = 0; i < 20; i++) begin
      if (i == 13) check("proto_err before oob", {31'b0, perr[1]}, 32'h0);
      txn(1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp,
          $sformatf("vec%0d", i));
    end
    check("proto_err after oob", {31'b0, perr[1]}, {31'b0, PE});

    // Zero wait states: single transactions then a back-to-back store/load.
    txn(0, 1'b1, 30'h7, 32'h0000A5A5, 4'hF, 32'h0, "ws0 store");
    txn(0, 1'b0, 30'h7, 32'h0,        4'hF, 32'h0000A5A5, "ws0 load");
    start[0] = 1'b1; write[0] = 1'b1; addr[0] = 30'h3; wdata[0] = 32'h5; be[0] = 4'hF;
    @(negedge clk);
    check("b2b store ready", {31'b0, ready[0]}, 32'h1);
    check("b2b store rd", rd[0], 32'h0);
    write[0] = 1'b0; wdata[0] = 32'h0;
    @(negedge clk);
    start[0] = 1'b0;
    check("b2b load ready", {31'b0, ready[0]}, 32'h1);
    check("b2b load rd", rd[0], 32'h5);
    @(negedge clk);
    check("b2b ready low", {31'b0, ready[0]}, 32'h0);
    check("ws0 proto_err", {31'b0, perr[0]}, 32'h0);

    // Three wait states: a second start while waiting is ignored.
    txn(2, 1'b1, 30'h40, 32'h0F0F0F0F, 4'hF, 32'h0, "ws3 store 40");
    txn(2, 1'b1, 30'h5,  32'h0,        4'hF, 32'h0, "ws3 store 5");
    start[2] = 1'b1; write[2] = 1'b0; addr[2] = 30'h40;
    @(negedge clk);
    nready = 0; first = 0; first_rd = 32'h0;
    for (int lat = 1; lat <= 10; lat++) begin
      if (ready[2]) begin
        nready++;
        if (first == 0) begin
          first = lat;
          first_rd = rd[2];
        end
      end
      if (lat == 1) addr[2] = 30'h41;
      if (lat == 2) start[2] = 1'b0;
      @(negedge clk);
    end
    check("wait-start ready count", 32'(nready), 32'd1);
    check("wait-start latency", 32'(first), 32'd4);
    check("wait-start data", first_rd, 32'h0F0F0F0F);
    check("wait-start proto_err", {31'b0, perr[2]}, {31'b0, PE});

    // Reset two cycles into a store abandons it.
    start[2] = 1'b1; write[2] = 1'b1; addr[2] = 30'h5; wdata[2] = 32'h12345678; be[2] = 4'hF;
    @(negedge clk);
    start[2] = 1'b0;
    nready = 0;
    for (int lat = 1; lat <= 8; lat++) begin
      if (ready[2]) nready++;
      if (lat == 2) rst = 1'b1;
      if (lat == 3) begin
        rst = 1'b0;
        check("mid-reset ready", {31'b0, ready[2]}, 32'h0);
        check("mid-reset rd", rd[2], 32'h0);
        check("mid-reset proto_err", {31'b0, perr[2]}, 32'h0);
      end
      @(negedge clk);
    end
    check("mid-reset no response", 32'(nready), 32'd0);
    txn(2, 1'b0, 30'h5, 32'h0, 4'hF, 32'h0, "after reset load 5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
